// File: rtl/collision_frame_latch.sv
// Latches per-pixel ball collision strobes over a frame and emits one masked bounce report at frame
// end. Optional COLL_STATS_EN adds a 16-bit wrapping count of reported bounces on total_bounces.
module collision_frame_latch #(
    parameter int unsigned FRAME_LINE     = 480,
    parameter int unsigned HOLDOFF_FRAMES = 3,
    parameter int unsigned CNT_W          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic             valid,
    input  logic [9:0]       h_cnt,
    input  logic [9:0]       v_cnt,
    input  logic             coll_x1,
    input  logic             coll_x2,
    input  logic             coll_y1,
    input  logic             coll_y2,
    output logic             frame_tick,
    output logic             bounce_valid,
    output logic [3:0]       bounce_flags,
    output logic             flip_x,
    output logic             flip_y,
    output logic [CNT_W-1:0] hit_count,
    output logic [15:0]      total_bounces
);

    localparam int unsigned HW = (HOLDOFF_FRAMES < 1) ? 1 : $clog2(HOLDOFF_FRAMES + 1);
    localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLDOFF_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             fe;
    logic [3:0]       coll;
    logic [3:0]       mask;
    logic [3:0]       masked;
    logic             rep_x;
    logic             rep_y;

    logic [3:0]       acc_q, acc_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [HW-1:0]    hold_x_q, hold_x_d;
    logic [HW-1:0]    hold_y_q, hold_y_d;
    logic             frame_tick_q, frame_tick_d;
    logic             bounce_valid_q, bounce_valid_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;

    assign fe     = pix_en && (v_cnt == 10'(FRAME_LINE)) && (h_cnt == 10'd0);
    assign coll   = {coll_x1, coll_x2, coll_y1, coll_y2};
    assign mask   = {{2{hold_x_q == '0}}, {2{hold_y_q == '0}}};
    assign masked = acc_q & mask;
    assign rep_x  = masked[3] | masked[2];
    assign rep_y  = masked[1] | masked[0];

    always_comb begin
        acc_d          = acc_q;
        acc_cnt_d      = acc_cnt_q;
        hold_x_d       = hold_x_q;
        hold_y_d       = hold_y_q;
        frame_tick_d   = 1'b0;
        bounce_valid_d = 1'b0;
        flags_d        = flags_q;
        hit_count_d    = hit_count_q;

        if (fe) begin
            frame_tick_d   = 1'b1;
            flags_d        = masked;
            bounce_valid_d = |masked;
            hit_count_d    = acc_cnt_q;
            acc_d          = '0;
            acc_cnt_d      = '0;
            // Only a reported axis reloads; masked hits just let the counter run down.
            if (rep_x) begin
                hold_x_d = HOLD_LOAD;
            end else if (hold_x_q != '0) begin
                hold_x_d = hold_x_q - HW'(1);
            end
            if (rep_y) begin
                hold_y_d = HOLD_LOAD;
            end else if (hold_y_q != '0) begin
                hold_y_d = hold_y_q - HW'(1);
            end
        end else if (pix_en && valid) begin
            acc_d = acc_q | coll;
            if ((|coll) && (acc_cnt_q != CNT_MAX)) begin
                acc_cnt_d = acc_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q          <= '0;
            acc_cnt_q      <= '0;
            hold_x_q       <= '0;
            hold_y_q       <= '0;
            frame_tick_q   <= 1'b0;
            bounce_valid_q <= 1'b0;
            flags_q        <= '0;
            hit_count_q    <= '0;
        end else begin
            acc_q          <= acc_d;
            acc_cnt_q      <= acc_cnt_d;
            hold_x_q       <= hold_x_d;
            hold_y_q       <= hold_y_d;
            frame_tick_q   <= frame_tick_d;
            bounce_valid_q <= bounce_valid_d;
            flags_q        <= flags_d;
            hit_count_q    <= hit_count_d;
        end
    end

    assign frame_tick   = frame_tick_q;
    assign bounce_valid = bounce_valid_q;
    assign bounce_flags = flags_q;
    assign flip_x       = flags_q[3] | flags_q[2];
    assign flip_y       = flags_q[1] | flags_q[0];
    assign hit_count    = hit_count_q;

`ifdef COLL_STATS_EN
    logic [15:0] total_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q <= '0;
        end else if (bounce_valid_d) begin
            total_q <= total_q + 16'd1;
        end
    end

    assign total_bounces = total_q;
`else
    assign total_bounces = 16'd0;
`endif

endmodule

// File: doc/collision_frame_latch.md
Name: collision_frame_latch

Overview:
Sits directly downstream of the per-pixel collision compare in the Pong top level, and upstream of the ball motion logic.
- Captures the four single-pixel collision strobes (left, right, top, bottom edge of the ball hitting a bouncing object) during the visible frame.
- Applies a per-axis hold-off so one paddle contact cannot flip direction repeatedly.
- Presents one registered, frame-aligned bounce report per frame in the system clk domain.

Parameters:
FRAME_LINE, 480, v_cnt value whose h_cnt==0 pixel marks end of frame / report point
HOLDOFF_FRAMES, 3, frames an axis stays masked after it reports a bounce (0 = no masking)
CNT_W, 4, width of saturating per-frame hit counter

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  asynchronous, active-low reset
pix_en  input  1  one-clk strobe per VGA pixel (pixel clock tick)
valid  input  1  VGA active-video flag
h_cnt  input  10  VGA horizontal counter
v_cnt  input  10  VGA vertical counter
coll_x1  input  1  ball left-edge collision
coll_x2  input  1  ball right-edge collision
coll_y1  input  1  ball top-edge collision
coll_y2  input  1  ball bottom-edge collision
frame_tick  output  1  one-clk pulse at each frame end
bounce_valid  output  1  one-clk pulse, coincident with frame_tick, when any unmasked flag is set
bounce_flags  output  4  {x1,x2,y1,y2} masked flags, held until next frame_tick
flip_x  output  1  bounce_flags[3]|bounce_flags[2], held
flip_y  output  1  bounce_flags[1]|bounce_flags[0], held
hit_count  output  CNT_W  saturating count of pixels with any collision in the last frame, held
total_bounces  output  16  see Optional Feature

Behaviour:
- Reset: rst low asynchronously clears all outputs to 0, the accumulator, the hit counter and both hold-off counters. Reset may assert mid-frame; accumulation restarts from zero and the first report occurs at the next frame end.
- All logic runs on clk. Inputs are acted on only in cycles where pix_en=1.
- Accumulate: when pix_en & valid, acc[i] |= coll[i]. If any coll is set, acc_cnt increments, saturating at 2^CNT_W-1. Collisions with valid=0 are ignored.
- Frame end (FE): pix_en & v_cnt==FRAME_LINE & h_cnt==0. Because valid is 0 there, a collision never coincides with FE.
- On FE, the next clk edge registers:
  - frame_tick=1.
  - bounce_flags = acc & {mx,mx,my,my}, where mx/my = 1 when the x/y hold-off counter is 0.
  - bounce_valid = |bounce_flags.
  - hit_count = acc_cnt.
  - acc and acc_cnt are cleared.
- Latency: FE sample cycle to frame_tick is 1 clk. frame_tick and bounce_valid last exactly 1 clk. flags, flip_x, flip_y and hit_count hold until the next FE.
- Hold-off, per axis, updated at FE:
  - If the axis reported (bit set after masking), load HOLDOFF_FRAMES.
  - Else, if nonzero, decrement by 1.
  - Masked-off hits neither reload nor extend the counter.
  - HOLDOFF_FRAMES=0 never masks.
- Simultaneous events: x1 and x2 in one frame are both reported (flip_x=1). x and y in one frame are both reported; each axis is held off independently.
- No handshake: the consumer samples on frame_tick. There is no backpressure.

Optional Feature:
COLL_STATS_EN
- Defined: total_bounces is a 16-bit counter, +1 on every bounce_valid, wrapping 65535->0, cleared by rst.
- Undefined: total_bounces is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset: hold rst=0 for 5 clk mid-frame with coll_x1 toggling -> all outputs 0, no frame_tick; release -> first frame_tick 1 clk after the FE pixel (v_cnt=480, h_cnt=0).
- Single hit: coll_y2=1 for one pix_en at (h=100, v=200, valid=1) -> at FE, bounce_valid=1, bounce_flags=4'b0001, flip_y=1, flip_x=0, hit_count=1.
- Hold-off: HOLDOFF_FRAMES=3, coll_x2 each frame for 6 frames -> bounce_valid in frames 1 and 5 only; flags 4'b0100 then 4'b0000 x3, then 4'b0100, then 4'b0000.
- Gating: coll_x1 asserted only with valid=0, or only in clk cycles with pix_en=0 -> frame_tick pulses, bounce_valid=0, hit_count=0.
- Saturation and simultaneity: 20 pixels with coll_x1&coll_y1 in one frame -> hit_count=15, bounce_flags=4'b1010, flip_x=flip_y=1.
- COLL_STATS_EN defined: 3 reported bounces -> total_bounces=3. Preload to 65535 via bounces -> next bounce gives 0. Undefined build -> total_bounces stays 0.
